// File: rtl/memory_bus_arbiter.sv
// Shares one AXI-Lite master port between the instruction-fetch path (read-only)
// and the data-memory path, one transaction at a time, round-robin on ties.
module memory_bus_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            i_Clock,
  input  logic            i_Reset,

  input  logic            i_Instr_Req_Valid,
  input  logic [XLEN-1:0] i_Instr_Req_Addr,
  output logic            o_Instr_Req_Ready,
  output logic            o_Instr_Resp_Valid,
  output logic [XLEN-1:0] o_Instr_Resp_Data,
  output logic            o_Instr_Resp_Error,

  input  logic            i_Data_Req_Valid,
  input  logic            i_Data_Req_Write,
  input  logic [XLEN-1:0] i_Data_Req_Addr,
  input  logic [XLEN-1:0] i_Data_Req_Wdata,
  input  logic [3:0]      i_Data_Req_Wstrb,
  output logic            o_Data_Req_Ready,
  output logic            o_Data_Resp_Valid,
  output logic [XLEN-1:0] o_Data_Resp_Rdata,
  output logic            o_Data_Resp_Error,

  output logic [XLEN-1:0] m_axil_araddr,
  output logic            m_axil_arvalid,
  input  logic            m_axil_arready,
  input  logic [XLEN-1:0] m_axil_rdata,
  input  logic [1:0]      m_axil_rresp,
  input  logic            m_axil_rvalid,
  output logic            m_axil_rready,
  output logic [XLEN-1:0] m_axil_awaddr,
  output logic            m_axil_awvalid,
  input  logic            m_axil_awready,
  output logic [XLEN-1:0] m_axil_wdata,
  output logic [3:0]      m_axil_wstrb,
  output logic            m_axil_wvalid,
  input  logic            m_axil_wready,
  input  logic [1:0]      m_axil_bresp,
  input  logic            m_axil_bvalid,
  output logic            m_axil_bready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR,
    S_WR_RESP,
    S_RESP
  } state_t;

  typedef enum logic {
    REQ_INSTR = 1'b0,
    REQ_DATA  = 1'b1
  } req_t;

  state_t          state_q, state_d;
  req_t            lastGrant_q, lastGrant_d;
  req_t            reqId_q, reqId_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic            awDone_q, awDone_d;
  logic            wDone_q, wDone_d;
  logic [XLEN-1:0] respData_q, respData_d;
  logic            respError_q, respError_d;
  logic            grantInstr, grantData;

  // A tie goes to whichever requester was not served last.
  assign grantInstr = i_Instr_Req_Valid &&
                      (!i_Data_Req_Valid || (lastGrant_q == REQ_DATA));
  assign grantData  = i_Data_Req_Valid &&
                      (!i_Instr_Req_Valid || (lastGrant_q == REQ_INSTR));

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q     <= S_IDLE;
      lastGrant_q <= REQ_DATA;
      reqId_q     <= REQ_INSTR;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awDone_q    <= 1'b0;
      wDone_q     <= 1'b0;
      respData_q  <= '0;
      respError_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      reqId_q     <= reqId_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awDone_q    <= awDone_d;
      wDone_q     <= wDone_d;
      respData_q  <= respData_d;
      respError_q <= respError_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    lastGrant_d        = lastGrant_q;
    reqId_d            = reqId_q;
    addr_d             = addr_q;
    wdata_d            = wdata_q;
    wstrb_d            = wstrb_q;
    awDone_d           = awDone_q;
    wDone_d            = wDone_q;
    respData_d         = respData_q;
    respError_d        = respError_q;
    o_Instr_Req_Ready  = 1'b0;
    o_Data_Req_Ready   = 1'b0;
    o_Instr_Resp_Valid = 1'b0;
    o_Data_Resp_Valid  = 1'b0;
    m_axil_arvalid     = 1'b0;
    m_axil_rready      = 1'b0;
    m_axil_awvalid     = 1'b0;
    m_axil_wvalid      = 1'b0;
    m_axil_bready      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        o_Instr_Req_Ready = grantInstr;
        o_Data_Req_Ready  = grantData;
        if (grantInstr) begin
          reqId_d     = REQ_INSTR;
          lastGrant_d = REQ_INSTR;
          addr_d      = i_Instr_Req_Addr;
          wdata_d     = '0;
          wstrb_d     = '0;
          state_d     = S_RD_ADDR;
        end else if (grantData) begin
          reqId_d     = REQ_DATA;
          lastGrant_d = REQ_DATA;
          addr_d      = i_Data_Req_Addr;
          wdata_d     = i_Data_Req_Wdata;
          wstrb_d     = i_Data_Req_Wstrb;
          state_d     = i_Data_Req_Write ? S_WR : S_RD_ADDR;
        end
      end

      S_RD_ADDR: begin
        m_axil_arvalid = 1'b1;
        if (m_axil_arready) begin
          state_d = S_RD_DATA;
        end
      end

      S_RD_DATA: begin
        m_axil_rready = 1'b1;
        if (m_axil_rvalid) begin
          respData_d  = m_axil_rdata;
          respError_d = (m_axil_rresp != 2'b00);
          state_d     = S_RESP;
        end
      end

      // AW and W retire independently; move on once both have handshaken.
      S_WR: begin
        m_axil_awvalid = !awDone_q;
        m_axil_wvalid  = !wDone_q;
        if ((awDone_q || m_axil_awready) && (wDone_q || m_axil_wready)) begin
          awDone_d = 1'b0;
          wDone_d  = 1'b0;
          state_d  = S_WR_RESP;
        end else begin
          awDone_d = awDone_q || m_axil_awready;
          wDone_d  = wDone_q || m_axil_wready;
        end
      end

      S_WR_RESP: begin
        m_axil_bready = 1'b1;
        if (m_axil_bvalid) begin
          respData_d  = '0;
          respError_d = (m_axil_bresp != 2'b00);
          state_d     = S_RESP;
        end
      end

      S_RESP: begin
        o_Instr_Resp_Valid = (reqId_q == REQ_INSTR);
        o_Data_Resp_Valid  = (reqId_q == REQ_DATA);
        state_d            = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign m_axil_araddr      = addr_q;
  assign m_axil_awaddr      = addr_q;
  assign m_axil_wdata       = wdata_q;
  assign m_axil_wstrb       = wstrb_q;
  assign o_Instr_Resp_Data  = respData_q;
  assign o_Instr_Resp_Error = respError_q;
  assign o_Data_Resp_Rdata  = respData_q;
  assign o_Data_Resp_Error  = respError_q;

endmodule

// File: doc/memory_bus_arbiter.md
# memory_bus_arbiter

Shares the CPU core's single AXI-Lite master port between two requesters: the instruction-fetch path (read-only) and the data-memory path (read/write). It accepts one request at a time, round-robin arbitrated when both are pending. It runs the complete AXI-Lite transaction, then returns a one-cycle response pulse to the granted requester. It sits between the instruction/data memory front-ends and the system interconnect; ROM-resident fetches never reach it.

## Interface
Parameters:
- XLEN, 32, address/data width (from cpu_core_params.vh; must be 32)

Ports:
- i_Clock  in  1  clock
- i_Reset  in  1  reset, asynchronous, active-high
- i_Instr_Req_Valid  in  1  fetch request pending
- i_Instr_Req_Addr  in  XLEN  fetch byte address
- o_Instr_Req_Ready  out  1  fetch request accepted this cycle
- o_Instr_Resp_Valid  out  1  one-cycle pulse, fetch data valid
- o_Instr_Resp_Data  out  XLEN  fetched word
- o_Instr_Resp_Error  out  1  RRESP was non-OKAY
- i_Data_Req_Valid  in  1  data request pending
- i_Data_Req_Write  in  1  1 = write, 0 = read
- i_Data_Req_Addr  in  XLEN  byte address
- i_Data_Req_Wdata  in  XLEN  write data
- i_Data_Req_Wstrb  in  4  byte strobes
- o_Data_Req_Ready  out  1  data request accepted this cycle
- o_Data_Resp_Valid  out  1  one-cycle pulse, data read/write complete
- o_Data_Resp_Rdata  out  XLEN  read data (0 after a write)
- o_Data_Resp_Error  out  1  RRESP/BRESP was non-OKAY
- m_axil_araddr/arvalid/arready, rdata/rresp/rvalid/rready, awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready  standard AXI-Lite master channels (32-bit addr/data, 2-bit resp)

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, RESP.
- IDLE grant, combinational from the valids:
  - Only one requester valid: that requester wins.
  - Both valid: the requester not granted last wins.
  - r_Last_Grant resets to DATA, so the first tie goes to instruction.
- o_X_Req_Ready = (state == IDLE) && grant_X. On acceptance, latch the following, then update r_Last_Grant:
  - requester id
  - address
  - write flag (instruction is always read)
  - wdata and wstrb
- Accepted read goes to RD_ADDR:
  - arvalid = 1, araddr = latched address.
  - On arready, go to RD_DATA.
  - RD_DATA: rready = 1. On rvalid, capture rdata into the response register, set error = (rresp != 0), go to RESP.
- Accepted write goes to WR:
  - awvalid and wvalid both assert. Each deasserts independently after its handshake, tracked by the r_Aw_Done and r_W_Done flags.
  - When both are done, clear the flags and go to WR_RESP.
  - WR_RESP: bready = 1. On bvalid, set error = (bresp != 0), zero rdata, go to RESP.
- RESP, one cycle:
  - Pulse the granted requester's Resp_Valid with registered data/error.
  - The other requester's Resp_Valid stays 0.
  - Return to IDLE.
- No address decoding or alignment check; requesters guarantee word-aligned addresses.
- Requester inputs are ignored outside IDLE. A request held valid waits.

## Timing
- Reset values:
  - State = IDLE.
  - Every AXI valid/ready output = 0.
  - Both Req_Ready outputs = 0 unless a valid is present in IDLE (combinational).
  - Both Resp_Valid = 0; response data/error = 0; r_Last_Grant = DATA.
- AXI address/data/strobe outputs come from latched registers and hold stable while their valid is high.
- Minimum read latency, with arready and rvalid already high:
  - Accept at cycle T.
  - arvalid at T+1.
  - rready at T+2.
  - Resp_Valid at T+3.
- Minimum write latency, with awready, wready and bvalid already high:
  - Accept at T.
  - AW/W at T+1.
  - bready at T+2.
  - Resp_Valid at T+3.
- AW and W handshakes may complete in the same cycle or in any order. Once a channel's handshake completes, that channel's valid is low on the next cycle.
- After RESP, the next acceptance happens no earlier than the following IDLE cycle. Back-to-back requests therefore cost 4 cycles minimum.
- A requester may drop Req_Valid before it is granted. Once Req_Ready is seen, the request is committed.
- Reset mid-transaction:
  - All outputs drop immediately and no response is issued.
  - The interconnect must be reset by the same i_Reset.

## Test plan
- Single fetch to 0x0000_2000, slave returns 0x0000_0013 with arready/rvalid immediate -> o_Instr_Resp_Valid pulses at T+3 with 0x0000_0013 and error 0; data port silent.
- Simultaneous fetch 0x2000 and data read 0x8000 held valid, with r_Last_Grant at reset -> instruction served first, then data. Repeat the same pair -> order alternates instr, data, instr, data.
- Data write addr 0x8004, wdata 0xDEADBEEF, wstrb 0x3, slave asserts wready 2 cycles before awready -> wvalid drops after W handshake, awvalid holds until its handshake. Then bready; o_Data_Resp_Valid pulses with rdata 0 and error 0. Slave observes exact addr/data/strobe.
- Slave returns rresp = 2'b10 on a data read -> o_Data_Resp_Error = 1 for the pulse cycle, rdata passed through.
- Slave holds arready low 5 cycles while fetch is in progress and the data requester asserts valid -> araddr stable, no data Req_Ready until the fetch response completes.
- i_Reset asserted during RD_DATA -> all AXI valid/ready outputs and Resp_Valid go 0 immediately. After release, a new fetch completes normally.
